// File: rtl/gzip_stored_inflate_pkg.sv
// Shared types and helpers for the stored-block gzip inflater.
// State encoding, error causes, gzip magic and a byte-wide CRC32 step.
package gzip_inflate_pkg;

  typedef enum logic [3:0] {
    S_HDR, S_BHDR, S_LEN0, S_LEN1, S_NLEN0,
    S_NLEN1, S_DATA, S_TRL, S_DONE, S_ERR
  } state_t;

  localparam int ERR_MAGIC = 1;
  localparam int ERR_FLG   = 2;
  localparam int ERR_BTYPE = 3;
  localparam int ERR_NLEN  = 4;
  localparam int ERR_CRC   = 5;
  localparam int ERR_ISIZE = 6;
  localparam int ERR_LEN   = 7;

  localparam logic [7:0] GZIP_ID1 = 8'h1F;
  localparam logic [7:0] GZIP_ID2 = 8'h8B;
  localparam logic [7:0] GZIP_CM  = 8'h08;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] crc,
    input logic [7:0]  b
  );
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/gzip_stored_inflate_if.sv
// Word input and byte output streams of the stored inflater.
// master = stream source/sink side, slave = inflater side.
interface gzip_stored_inflate_if;
  logic [31:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic [7:0]  out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;

  modport master (
    output in_tdata, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tvalid, out_tlast
  );

  modport slave (
    input  in_tdata, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tvalid, out_tlast
  );
endinterface

// File: rtl/gzip_stored_inflate_unpacker.sv
// gzip_word_unpacker: 32-bit word to byte splitter.
// Endianness is latched per word; refills with no bubble.
module gzip_word_unpacker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_tdata,
  input  logic        i_tvalid,
  output logic        o_tready,
  input  logic        i_rev,
  input  logic        i_take,
  input  logic        i_stop,
  input  logic        i_drain,
  output logic        o_bvalid,
  output logic [7:0]  o_byte
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic        r_full;
  logic        r_rev;
  logic        r_live;
  logic        w_load;
  logic [1:0]  w_sel;

  assign w_sel    = r_rev ? ~r_idx : r_idx;
  assign o_byte   = r_word[{w_sel, 3'b000} +: 8];
  assign o_bvalid = r_full & ~i_drain;
  // r_live keeps tready low through and just after reset
  assign o_tready = r_live & ~i_stop &
                    (i_drain | ~r_full |
                     (i_take & (r_idx == 2'd3)));
  assign w_load   = i_tvalid & o_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
      r_rev  <= 1'b0;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (i_drain) begin
        r_full <= 1'b0;
      end else if (w_load) begin
        r_word <= i_tdata;
        r_rev  <= i_rev;
        r_idx  <= '0;
        r_full <= 1'b1;
      end else if (i_take) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3)
          r_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gzip_stored_inflate.sv
// Stored-block (BTYPE=00) gzip inflater: strips headers,
// streams payload bytes and verifies the CRC32/ISIZE trailer.
module gzip_stored_inflate
  import gzip_inflate_pkg::*;
#(
  parameter int MAX_BLOCK_LEN = 65535,
  parameter int ERR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rev_endianess_in,
  gzip_stored_inflate_if.slave bus,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_code,
  output logic [31:0]      isize_out,
  output logic [31:0]      crc_out
);

  state_t r_state, w_nstate, w_blk_end;
  logic [3:0]  r_cnt;
  logic        r_bfinal;
  logic [15:0] r_len, r_rem;
  logic [7:0]  r_nlen0;
  logic [31:0] r_crc, r_isize;
  logic [7:0]  r_odata;
  logic        r_ovalid, r_olast;
  logic        r_done, r_err;
  logic [ERR_W-1:0] r_code, w_code;
  logic        w_take, w_fail, w_emit, w_bv;
  logic [7:0]  w_b, w_magic, w_exp;
  logic [63:0] w_trl;

  gzip_word_unpacker u_unpack (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_tdata  (bus.in_tdata),
    .i_tvalid (bus.in_tvalid),
    .o_tready (bus.in_tready),
    .i_rev    (rev_endianess_in),
    .i_take   (w_take),
    .i_stop   (r_state == S_ERR),
    .i_drain  (r_state == S_DONE),
    .o_bvalid (w_bv),
    .o_byte   (w_b)
  );

  assign w_blk_end = r_bfinal ? S_TRL : S_BHDR;
  assign w_magic = (r_cnt == 4'd0) ? GZIP_ID1 :
                   (r_cnt == 4'd1) ? GZIP_ID2 : GZIP_CM;
  assign w_trl = {r_isize, ~r_crc};
  assign w_exp = w_trl[{r_cnt[2:0], 3'b000} +: 8];
  assign w_emit = (r_state == S_DATA) & w_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HDR;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    if (w_fail) begin
      w_nstate = S_ERR;
    end else if (w_take) begin
      unique case (r_state)
        S_HDR:   if (r_cnt == 4'd9) w_nstate = S_BHDR;
        S_BHDR:  w_nstate = S_LEN0;
        S_LEN0:  w_nstate = S_LEN1;
        S_LEN1:  w_nstate = S_NLEN0;
        S_NLEN0: w_nstate = S_NLEN1;
        S_NLEN1: w_nstate = (r_len == '0) ? w_blk_end : S_DATA;
        S_DATA:  if (r_rem == 16'd1) w_nstate = w_blk_end;
        S_TRL:   if (r_cnt == 4'd7) w_nstate = S_DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_take = 1'b0;
    w_fail = 1'b0;
    w_code = '0;
    unique case (r_state)
      S_HDR: begin
        w_take = w_bv;
        if (w_bv && r_cnt <= 4'd2 && w_b != w_magic) begin
          w_fail = 1'b1;
          w_code = ERR_W'(ERR_MAGIC);
        end else if (w_bv && r_cnt == 4'd3 && w_b != 8'h00) begin
          w_fail = 1'b1;
          w_code = ERR_W'(ERR_FLG);
        end
      end
      S_BHDR: begin
        w_take = w_bv;
        if (w_bv && w_b[2:1] != 2'b00) begin
          w_fail = 1'b1;
          w_code = ERR_W'(ERR_BTYPE);
        end
      end
      S_LEN0, S_LEN1, S_NLEN0: w_take = w_bv;
      S_NLEN1: begin
        w_take = w_bv;
        if (w_bv && {w_b, r_nlen0} != ~r_len) begin
          w_fail = 1'b1;
          w_code = ERR_W'(ERR_NLEN);
        end else if (w_bv && {16'h0, r_len} > 32'(MAX_BLOCK_LEN)) begin
          w_fail = 1'b1;
          w_code = ERR_W'(ERR_LEN);
        end
      end
      S_DATA: w_take = w_bv & (~r_ovalid | bus.out_tready);
      S_TRL: begin
        // hold the trailer until the last payload byte has left
        w_take = w_bv & ~r_ovalid;
        if (w_take && w_b != w_exp) begin
          w_fail = 1'b1;
          w_code = r_cnt[2] ? ERR_W'(ERR_ISIZE) : ERR_W'(ERR_CRC);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_bfinal <= 1'b0;
      r_len    <= '0;
      r_nlen0  <= '0;
      r_rem    <= '0;
      r_crc    <= 32'hFFFFFFFF;
      r_isize  <= '0;
      r_odata  <= '0;
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= '0;
    end else begin
      if (w_take) begin
        r_cnt <= (w_nstate != r_state) ? 4'd0 : r_cnt + 4'd1;
        if (r_state == S_BHDR)  r_bfinal     <= w_b[0];
        if (r_state == S_LEN0)  r_len[7:0]   <= w_b;
        if (r_state == S_LEN1)  r_len[15:8]  <= w_b;
        if (r_state == S_NLEN0) r_nlen0      <= w_b;
        if (r_state == S_NLEN1) r_rem        <= r_len;
        if (r_state == S_DATA)  r_rem        <= r_rem - 16'd1;
      end
      if (w_emit) begin
        r_crc    <= crc32_byte(r_crc, w_b);
        r_isize  <= r_isize + 32'd1;
        r_odata  <= w_b;
        r_ovalid <= 1'b1;
        r_olast  <= r_bfinal & (r_rem == 16'd1);
      end else if (bus.out_tready) begin
        r_ovalid <= 1'b0;
        r_olast  <= 1'b0;
      end
      if (w_fail && !r_err) begin
        r_err  <= 1'b1;
        r_code <= w_code;
      end
      if (w_nstate == S_DONE) r_done <= 1'b1;
    end
  end

  assign bus.out_tdata  = r_odata;
  assign bus.out_tvalid = r_ovalid;
  assign bus.out_tlast  = r_olast;
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_code;
  assign isize_out = r_isize;
  assign crc_out   = ~r_crc;

endmodule

// File: tb/tb_gzip_stored_inflate.sv
// Testbench for gzip_stored_inflate: table of gzip streams,
// payload scoreboard, plus reset-state and mid-DATA reset sequences.
module tb_gzip_stored_inflate;

  logic        clk;
  logic        rst_n;
  logic        rev;
  logic        done, err;
  logic [2:0]  err_code;
  logic [31:0] isize_out, crc_out;

  gzip_stored_inflate_if bus();

  gzip_stored_inflate #(.MAX_BLOCK_LEN(65535), .ERR_W(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rev_endianess_in (rev),
    .bus              (bus),
    .done             (done),
    .err              (err),
    .err_code         (err_code),
    .isize_out        (isize_out),
    .crc_out          (crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } sb_t;

  typedef struct {
    string       name;
    int          kind;
    bit          rev;
    bit          tog;
    logic [2:0]  code;
    bit          done;
    logic [31:0] isize;
    bit          use_model;
    logic [31:0] crc;
    int          nbytes;
  } vec_t;

  int          n_tests = 0;
  int          n_fail = 0;
  int          rx_cnt = 0;
  bit          mon_en = 0;
  bit          tog = 0;
  bit          abort = 0;
  logic [7:0]  stim[$];
  sb_t         sb[$];
  logic [31:0] m_crc, m_isize;
  vec_t        v[10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_upd(input logic [31:0] c,
                                        input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  initial begin
    bus.out_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_tready = tog ? ~bus.out_tready : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_en && bus.out_tvalid && bus.out_tready) begin
      sb_t e;
      rx_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_byte", {bus.out_tdata, bus.out_tlast}, 9'h1FF);
      end else begin
        e = sb.pop_front();
        chk($sformatf("byte%0d", rx_cnt),
            {bus.out_tdata, bus.out_tlast}, {e.d, e.l});
      end
    end
  end

  task automatic blk(input logic [7:0] bt, input int len,
                     input logic [15:0] nlen, input logic [7:0] base,
                     input bit emit);
    logic [15:0] l16;
    l16 = 16'(len);
    stim.push_back(bt);
    stim.push_back(l16[7:0]);
    stim.push_back(l16[15:8]);
    stim.push_back(nlen[7:0]);
    stim.push_back(nlen[15:8]);
    for (int j = 0; j < len; j++) begin
      sb_t e;
      e.d = base + 8'(j);
      e.l = bt[0] && (j == len - 1);
      stim.push_back(e.d);
      if (emit) begin
        sb.push_back(e);
        m_crc = m_upd(m_crc, e.d);
        m_isize++;
      end
    end
  endtask

  task automatic trl(input logic [31:0] cx, input logic [31:0] ia);
    logic [31:0] c, s;
    c = ~m_crc ^ cx;
    s = m_isize + ia;
    for (int k = 0; k < 4; k++) stim.push_back(c[8*k +: 8]);
    for (int k = 0; k < 4; k++) stim.push_back(s[8*k +: 8]);
  endtask

  task automatic build(input int kind);
    logic [7:0] h[10];
    bit em;
    stim.delete();
    sb.delete();
    m_crc = 32'hFFFFFFFF;
    m_isize = 0;
    h = '{8'h1F, 8'h8B, 8'h08, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    if (kind == 2) h[2] = 8'h09;
    if (kind == 6) h[3] = 8'h08;
    for (int i = 0; i < 10; i++) stim.push_back(h[i]);
    em = !(kind == 2 || kind == 3 || kind == 6 || kind == 7);
    if (kind == 1 || kind == 5) begin
      blk(8'h00, 2, ~16'd2, 8'h41, 1'b1);
      if (kind == 1) blk(8'h01, 1, ~16'd1, 8'h43, 1'b1);
      else           blk(8'h01, 0, 16'hFFFF, 8'h00, 1'b1);
    end else begin
      blk(kind == 7 ? 8'h05 : 8'h01, 3,
          kind == 3 ? 16'hFFFF : ~16'd3, 8'h61, em);
    end
    trl(kind == 4 ? 32'h1 : 32'h0, kind == 8 ? 32'h1 : 32'h0);
    while (stim.size() % 4 != 0) stim.push_back(8'h00);
  endtask

  task automatic drive(input bit rv);
    int nw;
    nw = stim.size() / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] wd;
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (rv) wd[31-8*k -: 8] = stim[4*w+k];
        else    wd[8*k +: 8]    = stim[4*w+k];
      end
      bus.in_tdata  = wd;
      bus.in_tvalid = 1'b1;
      for (int c = 0; c < 100 && !ok && !abort && !err; c++) begin
        @(negedge clk);
        ok = bus.in_tready;
        @(posedge clk);
        #1;
      end
      if (!ok) break;
    end
    bus.in_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_tvalid = 1'b0;
    bus.in_tdata = '0;
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    rx_cnt = 0;
    mon_en = 1'b1;
  endtask

  function automatic vec_t mk(input string nm, input int kd,
                              input bit rv, input bit tg,
                              input logic [2:0] cd, input bit dn,
                              input logic [31:0] is, input bit um,
                              input logic [31:0] cr, input int nb);
    vec_t t;
    t.name = nm; t.kind = kd; t.rev = rv; t.tog = tg;
    t.code = cd; t.done = dn; t.isize = is;
    t.use_model = um; t.crc = cr; t.nbytes = nb;
    return t;
  endfunction

  initial begin
    v[0] = mk("abc",        0, 0, 0, 3'd0, 1, 3, 0, 32'h352441C2, 3);
    v[1] = mk("two_blk",    1, 0, 1, 3'd0, 1, 3, 1, 32'h0, 3);
    v[2] = mk("bad_magic",  2, 0, 0, 3'd1, 0, 0, 0, 32'h0, 0);
    v[3] = mk("bad_nlen",   3, 0, 0, 3'd4, 0, 0, 0, 32'h0, 0);
    v[4] = mk("bad_crc",    4, 0, 1, 3'd5, 0, 3, 0, 32'h352441C2, 3);
    v[5] = mk("len0_final", 5, 0, 0, 3'd0, 1, 2, 1, 32'h0, 2);
    v[6] = mk("bad_flg",    6, 0, 0, 3'd2, 0, 0, 0, 32'h0, 0);
    v[7] = mk("bad_btype",  7, 0, 0, 3'd3, 0, 0, 0, 32'h0, 0);
    v[8] = mk("bad_isize",  8, 0, 0, 3'd6, 0, 3, 0, 32'h352441C2, 3);
    v[9] = mk("abc_rev",    0, 1, 0, 3'd0, 1, 3, 0, 32'h352441C2, 3);

    rev = 1'b0;
    rst_n = 1'b0;
    bus.in_tvalid = 1'b0;
    bus.in_tdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_tready", bus.in_tready, 0);
    chk("rst.out_tvalid", bus.out_tvalid, 0);
    chk("rst.out_tlast", bus.out_tlast, 0);
    chk("rst.out_tdata", bus.out_tdata, 0);
    chk("rst.flags", {done, err, err_code}, 0);
    chk("rst.isize", isize_out, 0);
    chk("rst.crc", crc_out, 0);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] ecrc;
      do_reset();
      tog = v[i].tog;
      rev = v[i].rev;
      build(v[i].kind);
      ecrc = v[i].use_model ? ~m_crc : v[i].crc;
      drive(v[i].rev);
      for (int c = 0; c < 300 && !(done || err); c++) @(posedge clk);
      repeat (20) @(posedge clk);
      #1;
      chk({v[i].name, ".finished"}, done | err, 1);
      chk({v[i].name, ".err_code"}, err_code, v[i].code);
      chk({v[i].name, ".err"}, err, v[i].code != 0);
      chk({v[i].name, ".done"}, done, v[i].done);
      chk({v[i].name, ".isize"}, isize_out, v[i].isize);
      chk({v[i].name, ".crc"}, crc_out, ecrc);
      chk({v[i].name, ".nbytes"}, rx_cnt, v[i].nbytes);
      chk({v[i].name, ".sb_left"}, sb.size(), 0);
      chk({v[i].name, ".in_tready"}, bus.in_tready, v[i].done);
      chk({v[i].name, ".out_tvalid"}, bus.out_tvalid, 0);
    end

    begin
      bit seen;
      do_reset();
      tog = 1'b0;
      rev = 1'b0;
      build(0);
      mon_en = 1'b0;
      abort = 1'b0;
      seen = 1'b0;
      fork
        drive(1'b0);
      join_none
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        seen = bus.out_tvalid;
      end
      chk("mid.reached_data", seen, 1);
      rst_n = 1'b0;
      abort = 1'b1;
      #1;
      chk("mid.out_tvalid", bus.out_tvalid, 0);
      chk("mid.out_tdata", bus.out_tdata, 0);
      chk("mid.flags", {done, err, err_code, bus.out_tlast}, 0);
      chk("mid.isize", isize_out, 0);
      chk("mid.crc", crc_out, 0);
      chk("mid.in_tready", bus.in_tready, 0);
      wait fork;
      abort = 1'b0;
      sb.delete();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
